// File: rtl/uart_rx_mon_if.sv
// Serial receive bus: line inputs, the consumer handshake and the status outputs.
// The slave modport is the receiver; the master modport is whoever drives the line
// and consumes bytes.
interface uart_rx_mon_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic                 rts;
  logic                 data_ack;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  rxd, rts, data_ack,
    output data, data_valid, frame_err, overrun, busy
  );

  modport master (
    output rxd, rts, data_ack,
    input  data, data_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_mon.sv
// 8N1 UART receiver with a hold-until-acknowledged byte output.
// Raises one-cycle pulses for framing errors and overruns. A start bit is accepted
// only while the sender's rts is high. After a bad stop bit, the receiver waits for
// the line to go idle before it looks for the next start bit.
module uart_rx_mon #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_mon_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic [1:0]           rxd_sync_reg;
  logic [1:0]           rts_sync_reg;
  logic                 rxd_s;
  logic                 rts_s;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 data_valid_reg, data_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;

  // Two-flop synchronizers; rxd resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_sync_reg <= 2'b11;
      rts_sync_reg <= 2'b00;
    end else begin
      rxd_sync_reg <= {rxd_sync_reg[0], bus.rxd};
      rts_sync_reg <= {rts_sync_reg[0], bus.rts};
    end
  end

  assign rxd_s = rxd_sync_reg[1];
  assign rts_s = rts_sync_reg[1];

  // State register plus the counters and output registers, all driven from the next-state logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Next-state logic. START samples mid-bit; DATA and STOP sample one full bit later each time.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    data_valid_next = data_valid_reg;
    frame_err_next  = 1'b0;
    overrun_next    = 1'b0;

    // The acknowledge clears the byte. A byte completing in the same cycle overrides it below.
    if (bus.data_ack) begin
      data_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (!rxd_s && rts_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (!rxd_s) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_s, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rxd_s) begin
            data_next       = shift_reg;
            data_valid_next = 1'b1;
            overrun_next    = data_valid_reg && !bus.data_ack;
            state_next      = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BRK;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      BRK: begin
        if (rxd_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.data       = data_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_mon.sv
// Bench for uart_rx_mon: directed scenarios followed by random frames.
// Results are compared against a frame-level reference model.
module tb_uart_rx_mon;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic clk;
  logic rst;

  uart_rx_mon_if #(.DATA_BITS(DB)) bus ();

  uart_rx_mon #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the byte a consumer should see and whether it is pending.
  logic [7:0] exp_data;
  logic       exp_valid;

  // Per-frame monitor, updated every cycle just after the rising edge.
  int   mon_edge;
  int   mon_dv_edge;
  logic mon_prev_dv;
  int   mon_fe;
  int   mon_ov;
  logic mon_busy_any;
  logic mon_busy156;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_edge     = 0;
    mon_dv_edge  = -1;
    mon_prev_dv  = bus.data_valid;
    mon_fe       = 0;
    mon_ov       = 0;
    mon_busy_any = 1'b0;
    mon_busy156  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_edge++;
    if (!mon_prev_dv && bus.data_valid === 1'b1 && mon_dv_edge < 0) mon_dv_edge = mon_edge;
    mon_prev_dv = bus.data_valid;
    if (bus.frame_err === 1'b1) mon_fe++;
    if (bus.overrun === 1'b1) mon_ov++;
    if (bus.busy === 1'b1) mon_busy_any = 1'b1;
    if (mon_edge == 156) mon_busy156 = bus.busy;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drive one frame: start bit, data bits LSB first, then the stop level and a tail at tail_lvl.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int tail, input logic tail_lvl);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    mon_clear();
    for (int i = 0; i < 10; i++) begin
      bus.rxd = bits[i];
      repeat (CPB) tick();
    end
    bus.rxd = tail_lvl;
    repeat (tail) tick();
    bus.rxd = 1'b1;
  endtask

  // Frame-level model: a good stop with rts delivers the byte (overrun if one is still pending).
  // A bad stop only flags. Without rts the receiver never leaves idle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input logic stop, input logic rts_on);
    int exp_fe;
    int exp_ov;
    int exp_dv_edge;
    exp_fe      = 0;
    exp_ov      = 0;
    exp_dv_edge = -1;
    if (rts_on) begin
      if (stop) begin
        exp_ov      = exp_valid ? 1 : 0;
        exp_dv_edge = exp_valid ? -1 : (3 + CPB / 2 + (DB + 1) * CPB);
        exp_data    = b;
        exp_valid   = 1'b1;
      end else begin
        exp_fe = 1;
      end
    end
    check({tag, "_data"},     bus.data,       exp_data);
    check({tag, "_valid"},    bus.data_valid, exp_valid);
    check({tag, "_frameerr"}, mon_fe,         exp_fe);
    check({tag, "_overrun"},  mon_ov,         exp_ov);
    check({tag, "_dvedge"},   mon_dv_edge,    exp_dv_edge);
    check({tag, "_busyseen"}, mon_busy_any,   rts_on);
  endtask

  task automatic do_ack(input string tag);
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
    exp_valid = 1'b0;
    check({tag, "_ackclr"}, bus.data_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;

    rst          = 1'b0;
    bus.rxd      = 1'b1;
    bus.rts      = 1'b0;
    bus.data_ack = 1'b0;
    exp_data     = 8'h00;
    exp_valid    = 1'b0;
    mon_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  bus.data,       8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_fe",    bus.frame_err,  1'b0);
    check("rst_ov",    bus.overrun,    1'b0);
    check("rst_busy",  bus.busy,       1'b0);
    rst     = 1'b1;
    bus.rts = 1'b1;
    idle(5);

    // 0xA5: latency 155, busy gone by edge 156, ack clears next edge
    send_frame(8'hA5, 1'b1, 4, 1'b1);
    expect_frame("a5", 8'hA5, 1'b1, 1'b1);
    check("a5_busy156", mon_busy156, 1'b0);
    do_ack("a5");
    idle(3);

    // Short low glitch: start rejected at midpoint, no flags
    mon_clear();
    bus.rxd = 1'b0;
    idle(4);
    bus.rxd = 1'b1;
    idle(12);
    check("glitch_busyseen", mon_busy_any,   1'b1);
    check("glitch_busyend",  bus.busy,       1'b0);
    check("glitch_fe",       mon_fe,         0);
    check("glitch_valid",    bus.data_valid, 1'b0);
    idle(3);

    // Bad stop bit, line held low 40 cycles, then recovery with 0x81
    send_frame(8'h3C, 1'b0, 40, 1'b0);
    check("brk_holdbusy", bus.busy, 1'b1);
    expect_frame("brk", 8'h3C, 1'b0, 1'b1);
    idle(6);
    check("brk_idle", bus.busy, 1'b0);
    send_frame(8'h81, 1'b1, 4, 1'b1);
    expect_frame("x81", 8'h81, 1'b1, 1'b1);
    do_ack("x81");
    idle(2);

    // Two bytes without acknowledge: overrun on the second
    send_frame(8'h11, 1'b1, 4, 1'b1);
    expect_frame("ov1", 8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 4, 1'b1);
    expect_frame("ov2", 8'h22, 1'b1, 1'b1);

    // rts gating
    bus.rts = 1'b0;
    idle(5);
    send_frame(8'h55, 1'b1, 4, 1'b1);
    expect_frame("rts0", 8'h55, 1'b1, 1'b0);
    bus.rts = 1'b1;
    idle(5);
    send_frame(8'h55, 1'b1, 4, 1'b1);
    expect_frame("rts1", 8'h55, 1'b1, 1'b1);

    // Reset mid-way through 0xF0 while a byte is still pending
    mon_clear();
    for (int i = 0; i < 4; i++) begin
      bus.rxd = (i == 0) ? 1'b0 : ((8'hF0 >> (i - 1)) & 8'h01) != 0;
      repeat (CPB) tick();
    end
    rst = 1'b0;
    #1;
    check("mrst_data",  bus.data,       8'h00);
    check("mrst_valid", bus.data_valid, 1'b0);
    check("mrst_busy",  bus.busy,       1'b0);
    check("mrst_fe",    bus.frame_err,  1'b0);
    check("mrst_ov",    bus.overrun,    1'b0);
    bus.rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    idle(5);
    send_frame(8'h0F, 1'b1, 4, 1'b1);
    expect_frame("x0f", 8'h0F, 1'b1, 1'b1);

    // Random frames: random bytes, occasional bad stop bits, random acknowledges
    for (int r = 0; r < 10; r++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) do_ack("rnd");
      send_frame(rb, rstop, 6, 1'b1);
      expect_frame("rnd", rb, rstop, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
